hline_burst_engine: RTL and testbench
=====================================

HLINE_BURST_ENGINE -- requirements
Module: hline_burst_engine

Interface
REQ-001 SHALL have parameter BURST_LEN, default 256, meaning beats per burst (legal 1..256).
REQ-002 SHALL have clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have nreset, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have rd_go and wr_go, input, 1 each, single-cycle pulses that start a read or a write burst.
REQ-005 SHALL have addr, input, 32, the burst byte address, sampled on the go cycle.
REQ-006 SHALL have busy, done and err, output, 1 each: transfer in progress, one-cycle completion pulse, and error status valid with done.
REQ-007 SHALL have zfifo_wr (output, 1), zfifo_wdata (output, 32) and zfifo_full (input, 1) as the read-data FIFO push port.
REQ-008 SHALL have zout_rd (output, 1), zout_data (input, 32) and zout_empty (input, 1) as the FWFT z/rgbx write-data FIFO pop port.
REQ-009 SHALL have be_rd (output, 1), be_data (input, 4) and be_empty (input, 1) as the FWFT byte-enable FIFO pop port.
REQ-010 SHALL have m_axi_arvalid/arready/araddr/arlen/arsize/arburst, out/in/out/out/out/out, 1/1/32/8/3/2, as the AXI read address channel.
REQ-011 SHALL have m_axi_rvalid/rready/rdata/rresp/rlast, in/out/in/in/in, 1/1/32/2/1, as the AXI read data channel.
REQ-012 SHALL have m_axi_awvalid/awready/awaddr/awlen/awsize/awburst, out/in/out/out/out/out, 1/1/32/8/3/2, as the AXI write address channel.
REQ-013 SHALL have m_axi_wvalid/wready/wdata/wstrb/wlast, out/in/out/out/out, 1/1/32/4/1, as the AXI write data channel.
REQ-014 SHALL have m_axi_bvalid/bready/bresp, in/out/in, 1/1/2, as the AXI write response channel.

Function
REQ-015 SHALL implement states IDLE, AR, R, AW, W, B, DONE; busy = (state != IDLE).
REQ-016 SHALL in IDLE: on rd_go go to AR, else on wr_go go to AW; rd_go wins when both pulse together and that wr_go is dropped.
REQ-017 SHALL ignore rd_go/wr_go whenever state != IDLE.
REQ-018 SHALL go directly to DONE with err=1, issuing no AXI traffic, when addr[9:0] != 0 at go (1 KB alignment keeps bursts inside 4 KB).
REQ-019 SHALL register addr at go and drive ax*addr = addr, ax*len = BURST_LEN-1, ax*size = 3'b010, ax*burst = 2'b01 (INCR).
REQ-020 SHALL raise ar/awvalid the cycle after go and hold it with stable fields until arready/awready, then enter R/W.
REQ-021 SHALL in R drive rready = !zfifo_full and zfifo_wr = rvalid & rready, with zfifo_wdata = rdata on the same cycle (no register stage).
REQ-022 SHALL count accepted R beats with a 9-bit counter; on the beat carrying rlast go to DONE; rlast arriving early or late versus BURST_LEN sets err.
REQ-023 SHALL in W drive wvalid = !zout_empty & !be_empty, wdata = zout_data and wstrb = be_data.
REQ-024 SHALL pop zout_rd and be_rd together exactly on wvalid & wready.
REQ-025 SHALL assert wlast on beat BURST_LEN-1 and, after that beat is accepted, go to B.
REQ-026 SHALL in B drive bready = 1 and on bvalid go to DONE.
REQ-027 SHALL set err sticky within a transfer when any rresp or bresp != 2'b00.
REQ-028 SHALL in DONE pulse done for exactly one cycle with err valid, then return to IDLE.
REQ-029 SHALL clear err at the next accepted go.
REQ-030 SHALL allow a go in the cycle immediately after done (back-to-back z then framebuffer write).
REQ-031 SHALL stall W/R indefinitely on FIFO empty/full; there is no timeout.

Reset
REQ-032 SHALL on nreset low immediately (asynchronously) force state=IDLE, beat counter=0, err=0, done=0 and all valid/ready/pop/push outputs to 0, including mid-burst; the aborted burst is not resumed.
REQ-033 SHALL on nreset low drive address/len/data outputs to 0.

Verification
REQ-034 SHALL cover: rd_go, addr=0x1000_0400, BURST_LEN=256, arready after 3 cycles -> araddr held stable, 256 pushes of rdata in order, then done=1 and err=0.
REQ-035 SHALL cover: wr_go with FIFOs preloaded (zout=0..255, be alternating 4'hF/4'h0) -> wdata/wstrb match in order, wlast on beat 255, done after bvalid.
REQ-036 SHALL cover: zfifo_full toggling every 5 cycles during read -> rready tracks !zfifo_full, no beat lost or duplicated.
REQ-037 SHALL cover: rd_go and wr_go in the same cycle -> only the read executes; a wr_go issued 1 cycle after done is accepted.
REQ-038 SHALL cover: addr=0x0000_0004 -> no ar/awvalid, done and err asserted 1 cycle later; bresp=2'b10 -> err=1 with done.
REQ-039 SHALL cover: nreset asserted at write beat 100 -> all outputs 0 asynchronously; after release a fresh wr_go completes normally.

Source files
------------

// File: rtl/hline_burst_engine_if.sv
// hline_burst_engine_if
//   Bundles every non-clock/reset signal of hline_burst_engine: the go/status
//   strobes, the read-data FIFO push port, the FWFT write-data and
//   byte-enable FIFO pop ports, and the five AXI4 master channels.
//   modport master : engine side (drives AXI requests, FIFO push/pop, status)
//   modport slave  : environment side (AXI slave, FIFOs, go issuer)
interface hline_burst_engine_if;
  // Control / status
  logic        rd_go, wr_go;
  logic [31:0] addr;
  logic        busy, done, err;
  // Read-data FIFO push port
  logic        zfifo_wr;
  logic [31:0] zfifo_wdata;
  logic        zfifo_full;
  // FWFT z/rgbx write-data FIFO pop port
  logic        zout_rd;
  logic [31:0] zout_data;
  logic        zout_empty;
  // FWFT byte-enable FIFO pop port
  logic        be_rd;
  logic [3:0]  be_data;
  logic        be_empty;
  // AXI read address / data
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_rvalid, m_axi_rready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  // AXI write address / data / response
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_bvalid, m_axi_bready;
  logic [1:0]  m_axi_bresp;

  modport master (
    input  rd_go, wr_go, addr, zfifo_full, zout_data, zout_empty, be_data, be_empty,
           m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
           m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp,
    output busy, done, err, zfifo_wr, zfifo_wdata, zout_rd, be_rd,
           m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_rready, m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize,
           m_axi_awburst, m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
           m_axi_bready
  );

  modport slave (
    output rd_go, wr_go, addr, zfifo_full, zout_data, zout_empty, be_data, be_empty,
           m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
           m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp,
    input  busy, done, err, zfifo_wr, zfifo_wdata, zout_rd, be_rd,
           m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_rready, m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize,
           m_axi_awburst, m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
           m_axi_bready
  );
endinterface

// File: rtl/hline_burst_engine.sv
// hline_burst_engine
//   Moves one fixed-length AXI4 INCR burst (BURST_LEN beats of 32 bits) per
//   go pulse: a read burst streams R data straight into the read-data FIFO,
//   a write burst drains the FWFT z/rgbx and byte-enable FIFOs onto W.
//   Ports:
//     clk    - single clock, rising edge
//     nreset - asynchronous active-low reset
//     bus    - hline_burst_engine_if.master (go/status, FIFO ports, AXI)
//   Addresses not aligned to 1 KB are rejected with err and no AXI traffic,
//   which guarantees a 256-beat burst never crosses a 4 KB boundary.
module hline_burst_engine #(
  parameter int BURST_LEN = 256
) (
  input logic                  clk,
  input logic                  nreset,
  hline_burst_engine_if.master bus
);

  localparam logic [8:0] LAST_BEAT = 9'(BURST_LEN - 1);
  localparam logic [7:0] AX_LEN    = 8'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    // Every output is zero outside the state that owns it, so an
    // asynchronous reset (state forced to IDLE) zeroes them all at once.
    bus.busy          = (state_q != S_IDLE);
    bus.done          = 1'b0;
    bus.err           = err_q;
    bus.zfifo_wr      = 1'b0;
    bus.zfifo_wdata   = '0;
    bus.zout_rd       = 1'b0;
    bus.be_rd         = 1'b0;
    bus.m_axi_arvalid = 1'b0;
    bus.m_axi_araddr  = '0;
    bus.m_axi_arlen   = '0;
    bus.m_axi_arsize  = '0;
    bus.m_axi_arburst = '0;
    bus.m_axi_rready  = 1'b0;
    bus.m_axi_awvalid = 1'b0;
    bus.m_axi_awaddr  = '0;
    bus.m_axi_awlen   = '0;
    bus.m_axi_awsize  = '0;
    bus.m_axi_awburst = '0;
    bus.m_axi_wvalid  = 1'b0;
    bus.m_axi_wdata   = '0;
    bus.m_axi_wstrb   = '0;
    bus.m_axi_wlast   = 1'b0;
    bus.m_axi_bready  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // rd_go has priority; a simultaneous wr_go is simply dropped.
        if (bus.rd_go || bus.wr_go) begin
          addr_d = bus.addr;
          cnt_d  = '0;
          err_d  = (bus.addr[9:0] != 10'd0);
          if (bus.addr[9:0] != 10'd0) state_d = S_DONE;
          else if (bus.rd_go)          state_d = S_AR;
          else                         state_d = S_AW;
        end
      end
      S_AR: begin
        bus.m_axi_arvalid = 1'b1;
        bus.m_axi_araddr  = addr_q;
        bus.m_axi_arlen   = AX_LEN;
        bus.m_axi_arsize  = 3'b010;
        bus.m_axi_arburst = 2'b01;
        if (bus.m_axi_arready) state_d = S_R;
      end
      S_R: begin
        bus.m_axi_rready = !bus.zfifo_full;
        if (bus.m_axi_rvalid && !bus.zfifo_full) begin
          bus.zfifo_wr    = 1'b1;
          bus.zfifo_wdata = bus.m_axi_rdata;
          cnt_d           = cnt_q + 9'd1;
          if (bus.m_axi_rresp != 2'b00) err_d = 1'b1;
          // rlast must coincide with the final counted beat; early or
          // missing rlast is flagged, and the burst ends only on rlast.
          if (bus.m_axi_rlast) begin
            if (cnt_q != LAST_BEAT) err_d = 1'b1;
            state_d = S_DONE;
          end else if (cnt_q == LAST_BEAT) begin
            err_d = 1'b1;
          end
        end
      end
      S_AW: begin
        bus.m_axi_awvalid = 1'b1;
        bus.m_axi_awaddr  = addr_q;
        bus.m_axi_awlen   = AX_LEN;
        bus.m_axi_awsize  = 3'b010;
        bus.m_axi_awburst = 2'b01;
        if (bus.m_axi_awready) state_d = S_W;
      end
      S_W: begin
        bus.m_axi_wvalid = !bus.zout_empty && !bus.be_empty;
        bus.m_axi_wdata  = bus.zout_data;
        bus.m_axi_wstrb  = bus.be_data;
        bus.m_axi_wlast  = (cnt_q == LAST_BEAT);
        if (!bus.zout_empty && !bus.be_empty && bus.m_axi_wready) begin
          bus.zout_rd = 1'b1;
          bus.be_rd   = 1'b1;
          cnt_d       = cnt_q + 9'd1;
          if (cnt_q == LAST_BEAT) state_d = S_B;
        end
      end
      S_B: begin
        bus.m_axi_bready = 1'b1;
        if (bus.m_axi_bvalid) begin
          if (bus.m_axi_bresp != 2'b00) err_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hline_burst_engine.sv
module tb_hline_burst_engine;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  hline_burst_engine_if bus();

  hline_burst_engine #(.BURST_LEN(256)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard queues filled by the stimulus, drained by the monitor.
  logic [31:0] exp_r[$];
  logic [36:0] exp_w[$];      // {wlast, wstrb, wdata}
  logic        exp_done[$];   // expected err value at done
  logic        ar_ok, aw_ok, chk_rready;
  logic [31:0] exp_addr;

  // Behavioural FWFT FIFOs feeding the write channel.
  logic [31:0] zq[$];
  logic [3:0]  bq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout actual=none required=event", name);
  endtask

  function automatic logic [31:0] rdat(input int seed, input int i);
    return 32'(seed * 65536 + i * 4099 + 7);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fifo_outs();
    bus.zout_empty = (zq.size() == 0);
    bus.be_empty   = (bq.size() == 0);
    bus.zout_data  = (zq.size() != 0) ? zq[0] : 32'd0;
    bus.be_data    = (bq.size() != 0) ? bq[0] : 4'd0;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (nreset) begin
      if (bus.zfifo_wr) begin
        if (exp_r.size() == 0) chk("rpush_unexpected", bus.zfifo_wdata, 64'hDEAD);
        else chk("rpush_data", bus.zfifo_wdata, exp_r.pop_front());
      end
      if (bus.m_axi_wvalid && bus.m_axi_wready) begin
        if (exp_w.size() == 0) chk("wbeat_unexpected", bus.m_axi_wdata, 64'hDEAD);
        else chk("wbeat", {bus.m_axi_wlast, bus.m_axi_wstrb, bus.m_axi_wdata}, exp_w.pop_front());
      end
      chk("pop_pair", {bus.zout_rd, bus.be_rd},
          {2{bus.m_axi_wvalid & bus.m_axi_wready}});
      if (bus.m_axi_arvalid) begin
        chk("ar_allowed", ar_ok, 1'b1);
        chk("ar_fields", {bus.m_axi_araddr, bus.m_axi_arlen, bus.m_axi_arsize, bus.m_axi_arburst},
            {exp_addr, 8'd255, 3'b010, 2'b01});
      end
      if (bus.m_axi_awvalid) begin
        chk("aw_allowed", aw_ok, 1'b1);
        chk("aw_fields", {bus.m_axi_awaddr, bus.m_axi_awlen, bus.m_axi_awsize, bus.m_axi_awburst},
            {exp_addr, 8'd255, 3'b010, 2'b01});
      end
      if (chk_rready) chk("rready_tracks_full", bus.m_axi_rready, !bus.zfifo_full);
      if (bus.done) begin
        if (exp_done.size() == 0) chk("done_unexpected", bus.done, 1'b0);
        else chk("done_err", bus.err, exp_done.pop_front());
      end
    end
  end

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 20);
    if (!bus.done) timeout(name);
    tick();
  endtask

  task automatic do_read(input logic [31:0] a, input int seed, input int ar_delay,
                         input bit toggle_full);
    int i = 0;
    int cyc = 0;
    int n = 0;
    logic fire;
    for (int k = 0; k < 256; k++) exp_r.push_back(rdat(seed, k));
    exp_done.push_back(1'b0);
    exp_addr = a;
    ar_ok    = 1'b1;
    bus.rd_go = 1'b1;
    bus.addr  = a;
    tick();
    bus.rd_go = 1'b0;
    bus.wr_go = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.m_axi_arvalid && n < 10);
    if (!bus.m_axi_arvalid) begin
      timeout("read_arvalid");
      ar_ok = 1'b0;
      return;
    end
    repeat (ar_delay) tick();
    bus.m_axi_arready = 1'b1;
    tick();
    bus.m_axi_arready = 1'b0;
    ar_ok      = 1'b0;
    chk_rready = 1'b1;
    bus.m_axi_rvalid = 1'b1;
    bus.m_axi_rdata  = rdat(seed, 0);
    bus.m_axi_rlast  = 1'b0;
    while (i < 256 && cyc < 2000) begin
      @(negedge clk);
      fire = bus.m_axi_rvalid & bus.m_axi_rready;
      tick();
      cyc++;
      if (fire) i++;
      bus.m_axi_rvalid = (i < 256);
      bus.m_axi_rdata  = (i < 256) ? rdat(seed, i) : 32'd0;
      bus.m_axi_rlast  = (i == 255);
      bus.zfifo_full   = toggle_full && (((cyc / 5) % 2) == 1);
    end
    if (i < 256) timeout("read_beats");
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rlast  = 1'b0;
    bus.zfifo_full   = 1'b0;
    chk_rready       = 1'b0;
    wait_done("read_done");
  endtask

  task automatic do_write(input logic [31:0] a, input logic [1:0] bresp,
                          input int reset_at);
    int beats = 0;
    int cyc = 0;
    int n = 0;
    logic fire;
    for (int k = 0; k < 256; k++) begin
      zq.push_back(32'(k));
      bq.push_back((k % 2 == 0) ? 4'hF : 4'h0);
      exp_w.push_back({(k == 255), ((k % 2 == 0) ? 4'hF : 4'h0), 32'(k)});
    end
    exp_done.push_back(bresp != 2'b00);
    set_fifo_outs();
    exp_addr  = a;
    aw_ok     = 1'b1;
    bus.wr_go = 1'b1;
    bus.addr  = a;
    tick();
    bus.wr_go = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.m_axi_awvalid && n < 10);
    if (!bus.m_axi_awvalid) begin
      timeout("write_awvalid");
      aw_ok = 1'b0;
      return;
    end
    tick();
    bus.m_axi_awready = 1'b1;
    tick();
    bus.m_axi_awready = 1'b0;
    aw_ok = 1'b0;
    bus.m_axi_wready = 1'b1;
    while (beats < 256 && cyc < 2000) begin
      @(negedge clk);
      fire = bus.m_axi_wvalid & bus.m_axi_wready;
      tick();
      cyc++;
      if (fire) begin
        void'(zq.pop_front());
        void'(bq.pop_front());
        beats++;
      end
      set_fifo_outs();
      bus.m_axi_wready = ((cyc % 7) != 3);
      if (reset_at >= 0 && beats == reset_at) begin
        #2 nreset = 1'b0;
        #1;
        chk("rst_ctrl_outs",
            {bus.busy, bus.done, bus.err, bus.m_axi_arvalid, bus.m_axi_awvalid,
             bus.m_axi_wvalid, bus.m_axi_rready, bus.m_axi_bready, bus.zfifo_wr,
             bus.zout_rd, bus.be_rd, bus.m_axi_wlast}, 64'd0);
        chk("rst_addr_outs", {bus.m_axi_araddr, bus.m_axi_awaddr}, 64'd0);
        chk("rst_len_outs", {bus.m_axi_arlen, bus.m_axi_awlen, bus.m_axi_wstrb}, 64'd0);
        chk("rst_data_outs", {bus.m_axi_wdata, bus.zfifo_wdata}, 64'd0);
        exp_w.delete();
        exp_done.delete();
        zq.delete();
        bq.delete();
        set_fifo_outs();
        bus.m_axi_wready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        nreset = 1'b1;
        tick();
        return;
      end
    end
    if (beats < 256) timeout("write_beats");
    bus.m_axi_wready = 1'b0;
    repeat (2) tick();
    bus.m_axi_bvalid = 1'b1;
    bus.m_axi_bresp  = bresp;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.m_axi_bready && n < 20);
    if (!bus.m_axi_bready) timeout("write_bready");
    tick();
    bus.m_axi_bvalid = 1'b0;
    bus.m_axi_bresp  = 2'b00;
    wait_done("write_done");
  endtask

  initial begin
    nreset = 1'b0;
    ar_ok = 1'b0; aw_ok = 1'b0; chk_rready = 1'b0; exp_addr = '0;
    bus.rd_go = 1'b0; bus.wr_go = 1'b0; bus.addr = '0;
    bus.zfifo_full = 1'b0;
    bus.m_axi_arready = 1'b0; bus.m_axi_awready = 1'b0;
    bus.m_axi_rvalid = 1'b0; bus.m_axi_rdata = '0; bus.m_axi_rresp = 2'b00; bus.m_axi_rlast = 1'b0;
    bus.m_axi_wready = 1'b0; bus.m_axi_bvalid = 1'b0; bus.m_axi_bresp = 2'b00;
    set_fifo_outs();
    #2;
    chk("reset_status", {bus.busy, bus.done, bus.err}, 64'd0);
    chk("reset_valids", {bus.m_axi_arvalid, bus.m_axi_awvalid, bus.m_axi_wvalid,
                         bus.zfifo_wr, bus.zout_rd, bus.be_rd}, 64'd0);
    repeat (2) tick();
    nreset = 1'b1;
    tick();

    // Aligned read, arready held off 3 cycles
    do_read(32'h1000_0400, 1, 3, 1'b0);
    // Aligned write, FIFOs preloaded
    do_write(32'h2000_0800, 2'b00, -1);
    // Read with zfifo_full toggling every 5 cycles
    do_read(32'h1000_0800, 2, 0, 1'b1);
    // Simultaneous go: read only, then write one cycle after done
    bus.wr_go = 1'b1;
    do_read(32'h3000_0000, 3, 1, 1'b0);
    do_write(32'h3000_0400, 2'b00, -1);
    // Misaligned address: no AXI traffic, done+err one cycle later
    exp_done.push_back(1'b1);
    bus.wr_go = 1'b1;
    bus.addr  = 32'h0000_0004;
    tick();
    bus.wr_go = 1'b0;
    @(negedge clk);
    chk("misaligned_done_err", {bus.done, bus.err}, 2'b11);
    tick();
    tick();
    // Error write response
    do_write(32'h4000_0000, 2'b10, -1);
    // Reset mid-write at beat 100, then a fresh write
    do_write(32'h5000_0000, 2'b00, 100);
    chk("post_reset_idle", {bus.busy, bus.err}, 64'd0);
    do_write(32'h5000_0400, 2'b00, -1);

    repeat (3) tick();
    chk("leftover_r", 64'(exp_r.size()), 64'd0);
    chk("leftover_w", 64'(exp_w.size()), 64'd0);
    chk("leftover_done", 64'(exp_done.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
